// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// ALU codes, datapath mux selects and the controller state type.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_LOGIC = 2'b11;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_LOGIEX = 4'd12
    } state_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps the controller's coarse alu_op (plus funct / immediate-logic kind)
// onto the 3-bit ALU operation code.
module mips_alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    input  logic       imm_is_or,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                // Unrecognised funct falls back to ADD so the instruction still completes
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            ALUOP_LOGIC: alu_control = imm_is_or ? ALU_OR : ALU_AND;
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS Moore control FSM driving all datapath selects/enables.
// Define MC_IMM_LOGIC_EN to add andi/ori support (LOGIEX state, zero-extend).
module mips_mc_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       illegal
);

    state_t     state_q, state_d;
    logic       pc_write;
    logic       branch;
    logic       alu_active;
    logic [1:0] alu_op;
    logic [2:0] dec_alu_control;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_IMM_LOGIC_EN
                    OP_ANDI, OP_ORI: state_d = S_LOGIEX;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
`ifdef MC_IMM_LOGIC_EN
            S_LOGIEX: state_d = S_ADDIWB;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    // alu_active gates the decoder so states that do not use the ALU show 000
    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        ext_zero   = 1'b0;
        pc_src     = PCSRC_ALU;
        illegal    = 1'b0;
        alu_active = 1'b0;
        alu_op     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                alu_active = 1'b1;
                pc_src     = PCSRC_ALU;
                pc_write   = 1'b1;
            end
            S_DECODE: begin
                alu_src_b  = SRCB_IMM_SH2;
                alu_active = 1'b1;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
`ifdef MC_IMM_LOGIC_EN
                    OP_ANDI, OP_ORI: illegal = 1'b0;
`endif
                    default: illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_active = 1'b1;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_REG;
                alu_active = 1'b1;
                alu_op     = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_REG;
                alu_active = 1'b1;
                alu_op     = ALUOP_SUB;
                branch     = 1'b1;
                pc_src     = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_active = 1'b1;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
`ifdef MC_IMM_LOGIC_EN
            S_LOGIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                ext_zero   = 1'b1;
                alu_active = 1'b1;
                alu_op     = ALUOP_LOGIC;
            end
`endif
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

    mips_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (funct),
        .imm_is_or   (opcode[0]),
        .alu_control (dec_alu_control)
    );

    assign alu_control = alu_active ? dec_alu_control : 3'b000;
    assign pc_en       = pc_write | (branch & zero);

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed self-checking bench for mips_mc_control; expected output words are
// built from hand-derived per-state values. Honors MC_IMM_LOGIC_EN.
module tb_mips_mc_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, ext_zero, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [16:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    mips_mc_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .pc_en       (pc_en),
        .iord        (iord),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .ext_zero    (ext_zero),
        .alu_control (alu_control),
        .pc_src      (pc_src),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, ext_zero, alu_control, pc_src, illegal};

    function automatic logic [16:0] mk(input logic pe, input logic io, input logic mw,
                                       input logic irw, input logic rd, input logic m2r,
                                       input logic rw, input logic asa, input logic [1:0] asb,
                                       input logic ez, input logic [2:0] alu,
                                       input logic [1:0] pcs, input logic ill);
        return {pe, io, mw, irw, rd, m2r, rw, asa, asb, ez, alu, pcs, ill};
    endfunction

    // Expected output words per state, worked out by hand from the state table
    function automatic logic [16:0] e_fetch();      return mk(1,0,0,1,0,0,0,0,2'b01,0,3'b010,2'b00,0); endfunction
    function automatic logic [16:0] e_decode(input logic ill);
                                                    return mk(0,0,0,0,0,0,0,0,2'b11,0,3'b010,2'b00,ill); endfunction
    function automatic logic [16:0] e_memadr();     return mk(0,0,0,0,0,0,0,1,2'b10,0,3'b010,2'b00,0); endfunction
    function automatic logic [16:0] e_memrd();      return mk(0,1,0,0,0,0,0,0,2'b00,0,3'b000,2'b00,0); endfunction
    function automatic logic [16:0] e_memwb();      return mk(0,0,0,0,0,1,1,0,2'b00,0,3'b000,2'b00,0); endfunction
    function automatic logic [16:0] e_memwr();      return mk(0,1,1,0,0,0,0,0,2'b00,0,3'b000,2'b00,0); endfunction
    function automatic logic [16:0] e_exec(input logic [2:0] a);
                                                    return mk(0,0,0,0,0,0,0,1,2'b00,0,a,2'b00,0); endfunction
    function automatic logic [16:0] e_aluwb();      return mk(0,0,0,0,1,0,1,0,2'b00,0,3'b000,2'b00,0); endfunction
    function automatic logic [16:0] e_branch(input logic z);
                                                    return mk(z,0,0,0,0,0,0,1,2'b00,0,3'b110,2'b01,0); endfunction
    function automatic logic [16:0] e_addiex();     return mk(0,0,0,0,0,0,0,1,2'b10,0,3'b010,2'b00,0); endfunction
    function automatic logic [16:0] e_addiwb();     return mk(0,0,0,0,0,0,1,0,2'b00,0,3'b000,2'b00,0); endfunction
    function automatic logic [16:0] e_jump();       return mk(1,0,0,0,0,0,0,0,2'b00,0,3'b000,2'b10,0); endfunction
    function automatic logic [16:0] e_logiex(input logic [2:0] a);
                                                    return mk(0,0,0,0,0,0,0,1,2'b10,1,a,2'b00,0); endfunction

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode = op;
        funct  = fn;
        zero   = z;
    endtask

    task automatic checkOutput(input string tag, input logic [16:0] expected);
        n_checks++;
        assert (obs === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(6'b100011, 6'b000000, 1'b0);
        #3;
        checkOutput("reset_fetch", e_fetch());
        #9;
        rst_n = 1'b1;

        // lw: 5 cycles
        checkOutput("lw_fetch", e_fetch());
        tick(); checkOutput("lw_decode", e_decode(1'b0));
        tick(); checkOutput("lw_memadr", e_memadr());
        tick(); checkOutput("lw_memrd", e_memrd());
        tick(); checkOutput("lw_memwb", e_memwb());
        tick(); checkOutput("lw_back_fetch", e_fetch());

        // reset asserted in the middle of a lw (during MEMRD)
        tick(); checkOutput("rst_lw_decode", e_decode(1'b0));
        tick(); checkOutput("rst_lw_memadr", e_memadr());
        tick(); checkOutput("rst_lw_memrd", e_memrd());
        #1 rst_n = 1'b0;
        #1 checkOutput("rst_mid_fetch", e_fetch());
        #1 rst_n = 1'b1;
        #1 checkOutput("rst_release_fetch", e_fetch());
        tick(); checkOutput("rst_then_decode", e_decode(1'b0));
        tick(); checkOutput("rst_then_memadr", e_memadr());
        tick(); checkOutput("rst_then_memrd", e_memrd());
        tick(); checkOutput("rst_then_memwb", e_memwb());
        tick(); checkOutput("rst_then_fetch", e_fetch());

        // sw: 4 cycles
        applyStimulus(6'b101011, 6'b000000, 1'b0);
        tick(); checkOutput("sw_decode", e_decode(1'b0));
        tick(); checkOutput("sw_memadr", e_memadr());
        tick(); checkOutput("sw_memwr", e_memwr());
        tick(); checkOutput("sw_fetch", e_fetch());

        // R-type sub
        applyStimulus(6'b000000, 6'b100010, 1'b0);
        tick(); checkOutput("sub_decode", e_decode(1'b0));
        tick(); checkOutput("sub_exec", e_exec(3'b110));
        tick(); checkOutput("sub_aluwb", e_aluwb());
        tick(); checkOutput("sub_fetch", e_fetch());

        // R-type slt
        applyStimulus(6'b000000, 6'b101010, 1'b0);
        tick(); tick(); checkOutput("slt_exec", e_exec(3'b111));
        tick(); tick(); checkOutput("slt_fetch", e_fetch());

        // R-type and / or / unknown funct
        applyStimulus(6'b000000, 6'b100100, 1'b0);
        tick(); tick(); checkOutput("and_exec", e_exec(3'b000));
        tick(); tick();
        applyStimulus(6'b000000, 6'b100101, 1'b0);
        tick(); tick(); checkOutput("or_exec", e_exec(3'b001));
        tick(); tick();
        applyStimulus(6'b000000, 6'b111000, 1'b0);
        tick(); tick(); checkOutput("unk_funct_exec", e_exec(3'b010));
        tick(); checkOutput("unk_funct_aluwb", e_aluwb());
        tick(); checkOutput("unk_funct_fetch", e_fetch());

        // beq taken then not taken
        applyStimulus(6'b000100, 6'b000000, 1'b1);
        tick(); checkOutput("beq1_decode", e_decode(1'b0));
        tick(); checkOutput("beq1_branch", e_branch(1'b1));
        zero = 1'b0;
        #1 checkOutput("beq1_branch_zero_drop", e_branch(1'b0));
        zero = 1'b1;
        tick(); checkOutput("beq1_fetch", e_fetch());
        applyStimulus(6'b000100, 6'b000000, 1'b0);
        tick(); tick(); checkOutput("beq0_branch", e_branch(1'b0));
        tick(); checkOutput("beq0_fetch", e_fetch());

        // addi
        applyStimulus(6'b001000, 6'b000000, 1'b0);
        tick(); checkOutput("addi_decode", e_decode(1'b0));
        tick(); checkOutput("addi_ex", e_addiex());
        tick(); checkOutput("addi_wb", e_addiwb());
        tick(); checkOutput("addi_fetch", e_fetch());

        // j
        applyStimulus(6'b000010, 6'b000000, 1'b0);
        tick(); checkOutput("j_decode", e_decode(1'b0));
        tick(); checkOutput("j_jump", e_jump());
        tick(); checkOutput("j_fetch", e_fetch());

        // illegal opcode
        applyStimulus(6'b111111, 6'b000000, 1'b0);
        tick(); checkOutput("ill_decode", e_decode(1'b1));
        tick(); checkOutput("ill_fetch", e_fetch());

`ifdef MC_IMM_LOGIC_EN
        applyStimulus(6'b001101, 6'b000000, 1'b0);
        tick(); checkOutput("ori_decode", e_decode(1'b0));
        tick(); checkOutput("ori_logiex", e_logiex(3'b001));
        tick(); checkOutput("ori_wb", e_addiwb());
        tick(); checkOutput("ori_fetch", e_fetch());
        applyStimulus(6'b001100, 6'b000000, 1'b0);
        tick(); tick(); checkOutput("andi_logiex", e_logiex(3'b000));
        tick(); tick(); checkOutput("andi_fetch", e_fetch());
`else
        applyStimulus(6'b001101, 6'b000000, 1'b0);
        tick(); checkOutput("ori_decode_illegal", e_decode(1'b1));
        tick(); checkOutput("ori_fetch", e_fetch());
        applyStimulus(6'b001100, 6'b000000, 1'b0);
        tick(); checkOutput("andi_decode_illegal", e_decode(1'b1));
        tick(); checkOutput("andi_fetch", e_fetch());
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
